// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-tag encoding and default sizes.
package dmem_arbiter_pkg;

    localparam int unsigned AW_DEFAULT       = 10;
    localparam int unsigned DW_DEFAULT       = 32;
    localparam int unsigned MAX_WAIT_DEFAULT = 8;
    localparam int unsigned WAIT_W           = 8;

    // Owner of the read issued in the previous cycle
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CPU  = 2'b01,
        TAG_HOST = 2'b10
    } rd_tag_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_starvation_counter.sv
// Saturating count of consecutive cycles a requesting host has been denied.
module dmem_arbiter_starvation_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [WAIT_W-1:0] SAT_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_cnt;

    // Clear wins over increment; the count holds once it reaches the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + WAIT_W'(1);
        end
    end

    assign o_sat = (r_cnt == SAT_VAL);

endmodule : dmem_arbiter_starvation_counter

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU datapath and the host/debug port.
// Grants are combinational; read ownership is tracked one cycle to steer rvalid.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    // CPU port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    // Host port
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    // Memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic    w_wait_sat;
    logic    w_host_win;
    logic    w_wait_inc;
    logic    w_wait_clr;
    rd_tag_e r_rd_tag;
    rd_tag_e w_rd_tag_nxt;

    // Priority: CPU by default, host when CPU idle or host has waited the limit
    assign w_host_win = host_req & (~cpu_req | w_wait_sat);
    assign host_gnt   = rst & w_host_win;
    assign cpu_gnt    = rst & cpu_req & ~w_host_win;
    assign cpu_stall  = cpu_req & ~cpu_gnt;

    assign w_wait_inc = host_req & ~host_gnt;
    assign w_wait_clr = host_gnt | ~host_req;

    dmem_arbiter_starvation_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wait_inc),
        .i_clr (w_wait_clr),
        .o_sat (w_wait_sat)
    );

    // Steer the granted requester onto the memory port; idle port drives zeros
    always_comb begin
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Next read tag: owner of a granted read, NONE for writes and idle cycles
    always_comb begin
        w_rd_tag_nxt = TAG_NONE;
        if (cpu_gnt && !cpu_we) begin
            w_rd_tag_nxt = TAG_CPU;
        end else if (host_gnt && !host_we) begin
            w_rd_tag_nxt = TAG_HOST;
        end
    end

    // Read tag register; reset drops any in-flight return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_tag <= TAG_NONE;
        end else begin
            r_rd_tag <= w_rd_tag_nxt;
        end
    end

    assign cpu_rvalid  = (r_rd_tag == TAG_CPU);
    assign host_rvalid = (r_rd_tag == TAG_HOST);
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 1024x32 synchronous memory.
module tb_dmem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Expected read return: owner (1 = host), data, negedge index at which it is due
    typedef struct {
        logic          host;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] mem [0:1023];

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: write-first storage, registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Scoreboard: pop the expectation due this cycle, flag any unexpected return
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            n_total++; n_bad++;
            $display("FAIL rd_missed: host=%0b data=%h due=%0d now=%0d", e.host, e.data, e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_total++;
            if (e.host) begin
                if (host_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || host_rdata !== e.data) begin
                    n_bad++;
                    $display("FAIL host_rd: got hv=%b cv=%b data=%h exp hv=1 cv=0 data=%h cyc=%0d",
                             host_rvalid, cpu_rvalid, host_rdata, e.data, cyc);
                end
            end else begin
                if (cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0 || cpu_rdata !== e.data) begin
                    n_bad++;
                    $display("FAIL cpu_rd: got cv=%b hv=%b data=%h exp cv=1 hv=0 data=%h cyc=%0d",
                             cpu_rvalid, host_rvalid, cpu_rdata, e.data, cyc);
                end
            end
        end else if (cpu_rvalid === 1'b1 || host_rvalid === 1'b1) begin
            n_total++; n_bad++;
            $display("FAIL rd_unexpected: got cv=%b hv=%b exp cv=0 hv=0 cyc=%0d",
                     cpu_rvalid, host_rvalid, cyc);
        end
    end

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        cpu_req = 1'b1;
        host_req = 1'b1;
        #1;
        n_total++;
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_gnt: got cg=%b hg=%b en=%b we=%b exp all 0", cpu_gnt, host_gnt, mem_en, mem_we);
        end
        n_total++;
        if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rvalid: got cv=%b hv=%b exp 0 0", cpu_rvalid, host_rvalid);
        end
        repeat (2) @(negedge clk);
        drive_idle();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_total++;
            if (mem_en !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || cpu_stall !== 1'b0 ||
                cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset[%0d]: got en=%b cg=%b hg=%b st=%b cv=%b hv=%b exp all 0",
                         i, mem_en, cpu_gnt, host_gnt, cpu_stall, cpu_rvalid, host_rvalid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
        #1;
        n_total++;
        if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_en !== 1'b1 ||
            mem_we !== 1'b1 || mem_addr !== 10'h005 || mem_wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL cpu_wr: got cg=%b hg=%b st=%b en=%b we=%b a=%h d=%h exp 1 0 0 1 1 005 deadbeef",
                     cpu_gnt, host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        cpu_we = 1'b0; cpu_wdata = '0;
        #1;
        n_total++;
        if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
            n_bad++;
            $display("FAIL cpu_rd_gnt: got cg=%b en=%b we=%b a=%h exp 1 1 0 005", cpu_gnt, mem_en, mem_we, mem_addr);
        end
        sb.push_back('{host: 1'b0, data: 32'hDEADBEEF, due: cyc + 1});
        @(negedge clk);
        drive_idle();
        #1;
        n_total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL idle_port: got en=%b we=%b a=%h d=%h exp 0 0 0 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
    endtask

    // Host-only writes preload 0x010/0x011; CPU idle so host wins immediately
    task automatic test_host_only();
        logic [AW-1:0] addrs [2];
        logic [DW-1:0] datas [2];
        addrs[0] = 10'h010; datas[0] = 32'h00001234;
        addrs[1] = 10'h011; datas[1] = 32'h00005678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            host_req = 1'b1; host_we = 1'b1; host_addr = addrs[i]; host_wdata = datas[i];
            #1;
            n_total++;
            if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b1 ||
                mem_addr !== addrs[i] || mem_wdata !== datas[i]) begin
                n_bad++;
                $display("FAIL host_wr[%0d]: got hg=%b cg=%b st=%b we=%b a=%h d=%h exp 1 0 0 1 %h %h",
                         i, host_gnt, cpu_gnt, cpu_stall, mem_we, mem_addr, mem_wdata, addrs[i], datas[i]);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
        #1;
        n_total++;
        if (host_gnt !== 1'b1 || mem_addr !== 10'h010 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_host_gnt: got hg=%b a=%h we=%b exp 1 010 0", host_gnt, mem_addr, mem_we);
        end
        sb.push_back('{host: 1'b1, data: 32'h00001234, due: cyc + 1});
        @(negedge clk);
        host_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
        #1;
        n_total++;
        if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 10'h011) begin
            n_bad++;
            $display("FAIL b2b_cpu_gnt: got cg=%b hg=%b a=%h exp 1 0 011", cpu_gnt, host_gnt, mem_addr);
        end
        sb.push_back('{host: 1'b0, data: 32'h00005678, due: cyc + 1});
        @(negedge clk);
        drive_idle();
    endtask

    // Both requesters held high: host forced on every 9th cycle
    task automatic test_contention(input int ncyc, input string tag);
        logic exp_h;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
            host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
            #1;
            exp_h = ((k % 9) == 8);
            n_total++;
            if (host_gnt !== exp_h || cpu_gnt !== !exp_h || cpu_stall !== exp_h ||
                mem_addr !== (exp_h ? 10'h010 : 10'h005)) begin
                n_bad++;
                $display("FAIL %s[%0d]: got hg=%b cg=%b st=%b a=%h exp hg=%b cg=%b st=%b",
                         tag, k, host_gnt, cpu_gnt, cpu_stall, mem_addr, exp_h, !exp_h, exp_h);
            end
            sb.push_back('{host: exp_h, data: (exp_h ? 32'h00001234 : 32'hDEADBEEF), due: cyc + 1});
        end
        @(negedge clk);
        drive_idle();
    endtask

    // CPU write then host read of the same address next cycle returns the new data
    task automatic test_raw();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'hA5A50001;
        @(negedge clk);
        drive_idle();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h020;
        #1;
        n_total++;
        if (host_gnt !== 1'b1 || mem_addr !== 10'h020) begin
            n_bad++;
            $display("FAIL raw_gnt: got hg=%b a=%h exp 1 020", host_gnt, mem_addr);
        end
        sb.push_back('{host: 1'b1, data: 32'hA5A50001, due: cyc + 1});
        @(negedge clk);
        drive_idle();
    endtask

    // Reset right after a granted CPU read: return dropped, wait count cleared
    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
            host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
            #1;
            n_total++;
            if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
                n_bad++;
                $display("FAIL pre_rst[%0d]: got cg=%b hg=%b exp 1 0", k, cpu_gnt, host_gnt);
            end
            if (k < 4) sb.push_back('{host: 1'b0, data: 32'hDEADBEEF, due: cyc + 1});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0 ||
            mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: got cv=%b hv=%b cg=%b hg=%b en=%b exp all 0",
                     cpu_rvalid, host_rvalid, cpu_gnt, host_gnt, mem_en);
        end
        @(negedge clk);
        rst = 1'b1;
        test_contention(9, "post_rst");
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_host_only();
        test_back_to_back();
        test_contention(27, "contend");
        test_raw();
        test_reset_mid();
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish exp finish by 100000");
        $fatal(1);
    end

endmodule : tb_dmem_arbiter
